mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory port between two requesters: the multicycle CPU controller/datapath and a DMA/boot-loader port.
- Arbitrates per transaction, sequences the memory access with a fixed read latency, and returns data plus a one-cycle acknowledge to the winning requester.
- Sits between the processor's memory interface (memread/memwrite/address) and the memory macro.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory port around mem_port_arbiter.
// The arbiter connects through "slave"; requesters and the memory model use "master".
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
  logic          owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output mem_addr, mem_wdata, mem_we, mem_re, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  mem_addr, mem_wdata, mem_we, mem_re, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / DMA) arbiter for a single memory port with fixed read latency.
// Define ARB_CPU_PRIO_EN for fixed CPU priority; default is round-robin on conflicts.
module mem_port_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 2   // 1..15, held in a 4-bit counter
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic          cur_we;
  logic          grant_dma;
  logic          any_req;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;

  assign any_req = bus.cpu_req | bus.dma_req;

`ifdef ARB_CPU_PRIO_EN
  assign grant_dma = bus.dma_req & ~bus.cpu_req;
`else
  logic last_grant;

  // A conflict goes to whoever did not win last; reset favours the CPU.
  assign grant_dma = bus.dma_req & (~bus.cpu_req | ~last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_grant <= grant_dma;
    end
  end
`endif

  always_comb begin
    sel_addr  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
    sel_wdata = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
    sel_we    = grant_dma ? bus.dma_we    : bus.cpu_we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      cur_we        <= 1'b0;
      bus.owner     <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.dma_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_rdata <= '0;
    end else begin
      // Strobes and acks are single-cycle pulses unless re-asserted below.
      bus.mem_we  <= 1'b0;
      bus.mem_re  <= 1'b0;
      bus.cpu_ack <= 1'b0;
      bus.dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            bus.owner     <= grant_dma;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            cur_we        <= sel_we;
            bus.mem_we    <= sel_we;
            bus.mem_re    <= ~sel_we;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= LAT_M1;
          if (cur_we) begin
            bus.cpu_ack <= ~bus.owner;
            bus.dma_ack <= bus.owner;
            state       <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (bus.owner) bus.dma_rdata <= bus.mem_rdata;
            else           bus.cpu_rdata <= bus.mem_rdata;
            bus.cpu_ack <= ~bus.owner;
            bus.dma_ack <= bus.owner;
            state       <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (RD_LAT=2 and RD_LAT=1) with behavioural memories;
// stimulus queues expected strobes/acks, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(8), .DW(8)) b2 ();
  mem_port_arbiter_if #(.AW(8), .DW(8)) b1 ();

  mem_port_arbiter #(.AW(8), .DW(8), .RD_LAT(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  mem_port_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory models ----------------
  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'h10:   rom = 8'h5A;
      8'h30:   rom = 8'h11;
      8'h31:   rom = 8'h22;
      8'hFF:   rom = 8'h7E;
      8'h05:   rom = 8'hA5;
      default: rom = a ^ 8'h3C;
    endcase
  endfunction

  logic       wv2 [256];
  logic [7:0] wd2 [256];
  logic       p2a_v, p2b_v, p1a_v;
  logic [7:0] p2a_a, p2b_a, p1a_a;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) wv2[i] <= 1'b0;
    end else if (b2.mem_we) begin
      wv2[b2.mem_addr] <= 1'b1;
      wd2[b2.mem_addr] <= b2.mem_wdata;
    end
    p2a_v <= b2.mem_re; p2a_a <= b2.mem_addr;
    p2b_v <= p2a_v;     p2b_a <= p2a_a;
    p1a_v <= b1.mem_re; p1a_a <= b1.mem_addr;
  end

  always_comb begin
    b2.mem_rdata = 8'hEE;
    if (p2b_v === 1'b1) b2.mem_rdata = wv2[p2b_a] ? wd2[p2b_a] : rom(p2b_a);
    b1.mem_rdata = 8'hEE;
    if (p1a_v === 1'b1) b1.mem_rdata = rom(p1a_a);
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; int cyc; } mop_t;
  typedef struct { logic port; logic [7:0] rdata; logic [7:0] other; int cyc; } ack_t;
  mop_t mq0[$], mq1[$];
  ack_t aq0[$], aq1[$];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic exp_mem(input int d, input logic we, input logic [7:0] a, input logic [7:0] w, input int c);
    mop_t m;
    m.we = we; m.addr = a; m.wdata = w; m.cyc = c;
    if (d == 0) mq0.push_back(m); else mq1.push_back(m);
  endtask

  task automatic exp_ack(input int d, input logic p, input logic [7:0] rd, input logic [7:0] oth, input int c);
    ack_t a;
    a.port = p; a.rdata = rd; a.other = oth; a.cyc = c;
    if (d == 0) aq0.push_back(a); else aq1.push_back(a);
  endtask

  task automatic mon(input int d, input logic we, input logic re, input logic cack, input logic dack,
                     input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] crd,
                     input logic [7:0] drd, input logic own);
    mop_t m;
    ack_t a;
    bit   ok;
    if (we | re) begin
      ok = 0;
      if (d == 0 && mq0.size() > 0) begin m = mq0.pop_front(); ok = 1; end
      if (d == 1 && mq1.size() > 0) begin m = mq1.pop_front(); ok = 1; end
      if (!ok) chk("unexpected_strobe", d, {30'd0, we, re}, 32'd0);
      else begin
        chk("strobe_kind", d, {30'd0, we, re}, m.we ? 32'd2 : 32'd1);
        chk("mem_addr", d, {24'd0, addr}, {24'd0, m.addr});
        if (m.we) chk("mem_wdata", d, {24'd0, wdata}, {24'd0, m.wdata});
        chk("strobe_cycle", d, cyc, m.cyc);
      end
    end
    if (cack | dack) begin
      ok = 0;
      if (d == 0 && aq0.size() > 0) begin a = aq0.pop_front(); ok = 1; end
      if (d == 1 && aq1.size() > 0) begin a = aq1.pop_front(); ok = 1; end
      if (!ok) chk("unexpected_ack", d, {30'd0, cack, dack}, 32'd0);
      else begin
        chk("ack_port", d, {30'd0, cack, dack}, a.port ? 32'd1 : 32'd2);
        chk("ack_rdata", d, {24'd0, a.port ? drd : crd}, {24'd0, a.rdata});
        chk("other_rdata", d, {24'd0, a.port ? crd : drd}, {24'd0, a.other});
        chk("owner", d, {31'd0, own}, {31'd0, a.port});
        chk("ack_cycle", d, cyc, a.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, b2.mem_we, b2.mem_re, b2.cpu_ack, b2.dma_ack, b2.mem_addr, b2.mem_wdata,
        b2.cpu_rdata, b2.dma_rdata, b2.owner);
    mon(1, b1.mem_we, b1.mem_re, b1.cpu_ack, b1.dma_ack, b1.mem_addr, b1.mem_wdata,
        b1.cpu_rdata, b1.dma_rdata, b1.owner);
  end

  // ---------------- requester helpers ----------------
  task automatic set_cmd(input int d, input logic p, input logic req, input logic we,
                         input logic [7:0] a, input logic [7:0] w);
    if (d == 0 && !p)  begin b2.cpu_req = req; b2.cpu_we = we; b2.cpu_addr = a; b2.cpu_wdata = w; end
    else if (d == 0)   begin b2.dma_req = req; b2.dma_we = we; b2.dma_addr = a; b2.dma_wdata = w; end
    else if (!p)       begin b1.cpu_req = req; b1.cpu_we = we; b1.cpu_addr = a; b1.cpu_wdata = w; end
    else               begin b1.dma_req = req; b1.dma_we = we; b1.dma_addr = a; b1.dma_wdata = w; end
  endtask

  task automatic set_req(input int d, input logic p, input logic v);
    if (d == 0 && !p) b2.cpu_req = v;
    else if (d == 0)  b2.dma_req = v;
    else if (!p)      b1.cpu_req = v;
    else              b1.dma_req = v;
  endtask

  function automatic logic get_ack(input int d, input logic p);
    if (d == 0) return p ? b2.dma_ack : b2.cpu_ack;
    return p ? b1.dma_ack : b1.cpu_ack;
  endfunction

  function automatic logic [36:0] outs(input int d);
    if (d == 0)
      return {b2.cpu_ack, b2.dma_ack, b2.mem_we, b2.mem_re, b2.owner,
              b2.mem_addr, b2.mem_wdata, b2.cpu_rdata, b2.dma_rdata};
    return {b1.cpu_ack, b1.dma_ack, b1.mem_we, b1.mem_re, b1.owner,
            b1.mem_addr, b1.mem_wdata, b1.cpu_rdata, b1.dma_rdata};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int d, input logic p);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = get_ack(d, p);
    end
    if (!seen) chk(p ? "dma_ack_timeout" : "cpu_ack_timeout", d, {31'd0, seen}, 32'd1);
  endtask

  // Requester: after each ack, drop req for one cycle; re-raise unless this was the last one.
  task automatic serve(input int d, input logic p, input int n);
    for (int k = 0; k < n; k++) begin
      wait_ack(d, p);
      step(1);
      set_req(d, p, 1'b0);
      if (k < n - 1) begin
        step(1);
        set_req(d, p, 1'b1);
      end
    end
  endtask

  // ---------------- directed stimulus ----------------
  int i0;
  initial begin
    reset = 1'b1;
    set_cmd(0, 0, 0, 0, 8'h00, 8'h00); set_cmd(0, 1, 0, 0, 8'h00, 8'h00);
    set_cmd(1, 0, 0, 0, 8'h00, 8'h00); set_cmd(1, 1, 0, 0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("reset_outputs", 0, {27'd0, outs(0)[36:32]}, 32'd0);
    chk("reset_buses", 0, outs(0)[31:0], 32'd0);
    chk("reset_outputs", 1, {27'd0, outs(1)[36:32]}, 32'd0);
    chk("reset_buses", 1, outs(1)[31:0], 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // CPU read 0x10 -> 0x5A, RD_LAT=2
    step(1); i0 = cyc;
    set_cmd(0, 0, 1, 0, 8'h10, 8'h00);
    exp_mem(0, 0, 8'h10, 8'h00, i0 + 1);
    exp_ack(0, 0, 8'h5A, 8'h00, i0 + 4);
    serve(0, 0, 1);

    // DMA write 0xC3 -> 0x22
    step(1); i0 = cyc;
    set_cmd(0, 1, 1, 1, 8'h22, 8'hC3);
    exp_mem(0, 1, 8'h22, 8'hC3, i0 + 1);
    exp_ack(0, 1, 8'h00, 8'h5A, i0 + 2);
    serve(0, 1, 1);

    // Both held: CPU, DMA, CPU, DMA
    step(1); i0 = cyc;
    set_cmd(0, 0, 1, 0, 8'h30, 8'h00);
    set_cmd(0, 1, 1, 0, 8'h31, 8'h00);
    exp_mem(0, 0, 8'h30, 8'h00, i0 + 1);
    exp_mem(0, 0, 8'h31, 8'h00, i0 + 6);
    exp_mem(0, 0, 8'h30, 8'h00, i0 + 11);
    exp_mem(0, 0, 8'h31, 8'h00, i0 + 16);
    exp_ack(0, 0, 8'h11, 8'h00, i0 + 4);
    exp_ack(0, 1, 8'h22, 8'h11, i0 + 9);
    exp_ack(0, 0, 8'h11, 8'h22, i0 + 14);
    exp_ack(0, 1, 8'h22, 8'h11, i0 + 19);
    fork
      serve(0, 0, 2);
      serve(0, 1, 2);
    join

    // CPU write 0x99 -> 0x40 so the CPU is the last grant
    step(1); i0 = cyc;
    set_cmd(0, 0, 1, 1, 8'h40, 8'h99);
    exp_mem(0, 1, 8'h40, 8'h99, i0 + 1);
    exp_ack(0, 0, 8'h11, 8'h22, i0 + 2);
    serve(0, 0, 1);

    // Simultaneous: CPU reads 0x40, DMA writes 0x77 -> 0x41
    step(1); i0 = cyc;
    set_cmd(0, 0, 1, 0, 8'h40, 8'h00);
    set_cmd(0, 1, 1, 1, 8'h41, 8'h77);
`ifdef ARB_CPU_PRIO_EN
    exp_mem(0, 0, 8'h40, 8'h00, i0 + 1);
    exp_mem(0, 1, 8'h41, 8'h77, i0 + 6);
    exp_ack(0, 0, 8'h99, 8'h22, i0 + 4);
    exp_ack(0, 1, 8'h22, 8'h99, i0 + 7);
`else
    exp_mem(0, 1, 8'h41, 8'h77, i0 + 1);
    exp_mem(0, 0, 8'h40, 8'h00, i0 + 4);
    exp_ack(0, 1, 8'h22, 8'h11, i0 + 2);
    exp_ack(0, 0, 8'h99, 8'h22, i0 + 7);
`endif
    fork
      serve(0, 0, 1);
      serve(0, 1, 1);
    join

    // Reset during WAIT of a CPU read, then re-serve the held request
    step(1); i0 = cyc;
    set_cmd(0, 0, 1, 0, 8'h10, 8'h00);
    exp_mem(0, 0, 8'h10, 8'h00, i0 + 1);
    step(2);
    reset = 1'b1;
    #1;
    chk("midreset_outputs", 0, {27'd0, outs(0)[36:32]}, 32'd0);
    chk("midreset_buses", 0, outs(0)[31:0], 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    i0 = cyc;
    exp_mem(0, 0, 8'h10, 8'h00, i0 + 1);
    exp_ack(0, 0, 8'h5A, 8'h00, i0 + 4);
    serve(0, 0, 1);

    // RD_LAT=1: CPU read 0xFF -> 0x7E, DMA read of 0x05 raised during WAIT
    step(1); i0 = cyc;
    set_cmd(1, 0, 1, 0, 8'hFF, 8'h00);
    exp_mem(1, 0, 8'hFF, 8'h00, i0 + 1);
    exp_mem(1, 0, 8'h05, 8'h00, i0 + 5);
    exp_ack(1, 0, 8'h7E, 8'h00, i0 + 3);
    exp_ack(1, 1, 8'hA5, 8'h7E, i0 + 7);
    fork
      serve(1, 0, 1);
      begin
        step(2);
        set_cmd(1, 1, 1, 0, 8'h05, 8'h00);
        serve(1, 1, 1);
      end
    join

    step(3);
    chk("pending_strobes", 0, mq0.size(), 32'd0);
    chk("pending_acks", 0, aq0.size(), 32'd0);
    chk("pending_strobes", 1, mq1.size(), 32'd0);
    chk("pending_acks", 1, aq1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", nerr);
    $fatal(1, "watchdog");
  end

endmodule
